// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end.
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_t;

  typedef enum logic [1:0] {
    FF_NONE     = 2'b00,
    FF_MISALIGN = 2'b01,
    FF_TIMEOUT  = 2'b10
  } fetch_fault_t;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Cycle counter that flags when a memory wait has lasted TIMEOUT cycles.
module fetch_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;

  // Count enabled cycles, saturating at TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable && (count_q != CNT_W'(TIMEOUT))) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // High during the TIMEOUT-th enabled cycle, so the fault lands at its closing edge.
  assign expired = enable && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues word reads to instruction memory and hands the result to decode.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        TIMEOUT  = 16,
  parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              decode_ready,
  output logic [1:0]        fetch_fault,
  output logic              pc_en
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              issued_q, issued_d;
  logic              discard_q, discard_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  fetch_fault_t      fault_q, fault_d;
  logic              expired;
  logic [ADDR_W-1:0] req_addr;
  logic              drop;

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != S_WAIT),
    .enable  (state_q == S_WAIT),
    .expired (expired)
  );

  // First request cycle uses the live PC; once issued the latched address is held until gnt.
  assign req_addr = issued_q ? addr_q : {pc_in[ADDR_W-1:2], 2'b00};
  assign drop     = discard_q | flush;

  // State register and held instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      issued_q  <= 1'b0;
      discard_q <= 1'b0;
      out_q     <= '0;
      pc_q      <= '0;
      fault_q   <= FF_NONE;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      issued_q  <= issued_d;
      discard_q <= discard_d;
      out_q     <= out_d;
      pc_q      <= pc_d;
      fault_q   <= fault_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issued_d    = 1'b0;
    discard_d   = discard_q;
    out_d       = out_q;
    pc_d        = pc_q;
    fault_d     = fault_q;
    imem_req    = 1'b0;
    imem_addr   = addr_q;
    instr_valid = (state_q == S_HOLD);
    pc_en       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        imem_addr = req_addr;
        if (!issued_q && !is_word_aligned(pc_in[1:0])) begin
          // A flush replaces the PC, so only raise the fault if none is pending.
          if (!flush) begin
            out_d   = NOP_WORD;
            pc_d    = pc_in;
            fault_d = FF_MISALIGN;
            state_d = S_HOLD;
          end
        end else begin
          imem_req = 1'b1;
          addr_d   = req_addr;
          if (imem_gnt) begin
            state_d   = S_WAIT;
            discard_d = flush;
          end else if (!flush) begin
            issued_d = 1'b1;
          end
        end
      end

      S_WAIT: begin
        if (imem_rvalid) begin
          if (drop) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            out_d   = imem_rdata;
            pc_d    = addr_q;
            fault_d = FF_NONE;
            state_d = S_HOLD;
          end
        end else if (expired) begin
          // A flushed fetch that times out has nothing worth reporting.
          if (drop) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            out_d   = NOP_WORD;
            pc_d    = addr_q;
            fault_d = FF_TIMEOUT;
            state_d = S_HOLD;
          end
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (flush) begin
          state_d = S_REQ;
        end else if (decode_ready) begin
          pc_en   = 1'b1;
          state_d = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign instr_out   = out_q;
  assign instr_pc    = pc_q;
  assign fetch_fault = fault_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the PC/branch-target block.
- Samples the current PC, issues a word request to instruction memory over a req/gnt + rvalid handshake, and captures the returned word in an instruction register.
- Presents the instruction to decode with valid/ready and drives pc_en back to the PC block, so the PC advances only when an instruction is consumed.
- Handles flush (taken branch), misaligned PC and memory timeout.

Parameters:
- ADDR_W, 32, PC/address width
- DATA_W, 32, instruction width
- TIMEOUT, 16, max cycles in S_WAIT before fault; counter width $clog2(TIMEOUT+1)
- NOP_WORD, 32'h0000_0000, instruction emitted on fault (MIPS sll $0,$0,0)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- pc_in  in  ADDR_W  current PC from PC block
- flush  in  1  discard in-flight/held instruction (branch taken)
- imem_req  out  1  memory request valid
- imem_addr  out  ADDR_W  request address (word aligned)
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  DATA_W  read data
- instr_valid  out  1  instr_out valid to decode
- instr_out  out  DATA_W  fetched instruction
- instr_pc  out  ADDR_W  PC of instr_out
- decode_ready  in  1  decode consumes instruction
- fetch_fault  out  2  00 none, 01 misaligned, 10 timeout; valid with instr_valid
- pc_en  out  1  PC may update this cycle

Behaviour:
- Reset (sync, active-high, dominates everything): state=S_IDLE. imem_req=0, imem_addr=0, instr_valid=0, instr_out=0, instr_pc=0, fetch_fault=00, pc_en=0, timeout counter=0, discard flag=0.
- S_IDLE: go to S_REQ next cycle. Exists only to give one settle cycle after reset.
- S_REQ:
  - If pc_in[1:0]!=0: no request. Load instr_out=NOP_WORD, instr_pc=pc_in, fetch_fault=01. Go to S_HOLD.
  - Else: imem_req=1, imem_addr=pc_in, with address latched on entry. Address and req are held stable until imem_gnt. On gnt go to S_WAIT with counter cleared.
- S_WAIT: imem_req=0; counter increments each cycle.
  - On imem_rvalid: if discard=0, capture rdata into instr_out, instr_pc=latched addr, fault=00, go to S_HOLD. If discard=1, drop the data, clear discard, go to S_REQ.
  - If counter reaches TIMEOUT without rvalid: instr_out=NOP_WORD, fault=10, go to S_HOLD. A later stray rvalid is ignored.
- S_HOLD: instr_valid=1; outputs stable until accepted.
  - On decode_ready: pc_en=1 for exactly that cycle (combinational: instr_valid & decode_ready & ~flush). Go to S_REQ. The PC block updates at that edge, so the next S_REQ sees the new pc_in.
- Latency: best case S_REQ(gnt same cycle) → S_WAIT(rvalid same cycle) → S_HOLD. instr_valid rises 2 cycles after S_REQ entry. Sustained throughput is 1 instruction per 3 cycles.
- flush:
  - In S_REQ before gnt: request is withdrawn next cycle, re-enter S_REQ and resample pc_in.
  - In S_REQ with gnt in the same cycle: go to S_WAIT with discard=1.
  - In S_WAIT: set discard=1.
  - In S_HOLD: drop instr_valid, go to S_REQ, pc_en=0.
  - flush and decode_ready together: flush wins, no pc_en.
- pc_en is 0 in every state except the S_HOLD accept cycle. The PC must hold otherwise.
- Reset mid-transaction: the outstanding memory response is not tracked. The memory model is reset together with this block.
- instr_valid is never asserted in S_IDLE, S_REQ or S_WAIT.

Decomposition:
- Shared package mips_pkg:
  - fetch_state_t enum {S_IDLE, S_REQ, S_WAIT, S_HOLD}
  - fetch_fault_t enum {FF_NONE, FF_MISALIGN, FF_TIMEOUT}
  - localparam NOP_INSTR
- One sub-module is natural: fetch_timeout_ctr (clear/enable/expired, parameterised by TIMEOUT).

Test Plan:
- Zero-wait memory (gnt and rvalid combinational, rvalid the cycle after gnt), pc_in=0x0, then 0x4; rdata=0x2002_0005 and 0x0043_2020; decode_ready=1 → instr_valid 2 cycles after S_REQ, pc_en pulses once per instruction, instr_pc 0x0 then 0x4.
- gnt delayed 3 cycles → imem_addr=0x0000_0010 and imem_req held constant for 3 cycles; instr_out equals rdata.
- decode_ready low for 4 cycles in S_HOLD → instr_out/instr_pc stable, pc_en=0 throughout; pc_en=1 only in the cycle decode_ready rises.
- flush asserted in S_WAIT, rvalid returns 0xDEAD_BEEF 2 cycles later → data dropped, no instr_valid; next request uses new pc_in=0x40.
- pc_in=0x0000_0006 → no imem_req; instr_valid with instr_out=0x0, fetch_fault=01.
- rvalid withheld, TIMEOUT=16 → fetch_fault=10, instr_out=NOP on cycle 16 of S_WAIT. rst pulsed mid-S_WAIT → all outputs reset values next cycle.
